pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines load-use

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and the stall/flush sequencer (slave).
// The master drives hazard information; the slave returns per-stage stall/flush controls.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_mc_start;
   logic             mc_done;
   logic             flush_needed;
   logic             imem_ready;

   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_flush;
   logic             exmem_bubble;
   logic             mc_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic [1:0]       dbg_state;

   // No valid/ready pairs here: every control is a level, and a stall is the only back-pressure.
   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_mc_start, mc_done, flush_needed, imem_ready,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble,
             mc_timeout, stall_cycles, flush_count, dbg_state
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_mc_start, mc_done, flush_needed, imem_ready,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble,
             mc_timeout, stall_cycles, flush_count, dbg_state
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle EX,
// fetch wait and redirect flushes merged into per-stage controls plus perf counters.
module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_flag;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   logic load_use;
   logic mc_begin;
   logic flush_accept;
   logic pc_stall;
   logic ifid_stall;
   logic ifid_flush;
   logic idex_stall;
   logic idex_flush;
   logic exmem_bubble;

   assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                     ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // A multi-cycle op whose result arrives in its start cycle costs nothing.
   assign mc_begin = (state == RUN) && hz.ex_mc_start && !hz.mc_done;

   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      flush_accept = 1'b0;
      if (!rst) begin
         if ((state == MC_WAIT) || mc_begin) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
         end else if (hz.flush_needed) begin
            // Redirect wins over load-use and fetch wait: those instructions are wrong-path.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            flush_accept = 1'b1;
         end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
         end else if (!hz.imem_ready) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
         stall_cnt    <= '0;
         flush_cnt    <= '0;
      end else begin
         if (pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush_accept && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         case (state)
            RUN: begin
               if (mc_begin) begin
                  state    <= MC_WAIT;
                  wait_cnt <= '0;
               end
            end
            MC_WAIT: begin
               // mc_done in the last allowed cycle still completes normally.
               if (hz.mc_done) begin
                  state <= RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout_flag <= 1'b1;
                  state        <= RUN;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign hz.pc_stall     = pc_stall;
   assign hz.ifid_stall   = ifid_stall;
   assign hz.ifid_flush   = ifid_flush;
   assign hz.idex_stall   = idex_stall;
   assign hz.idex_flush   = idex_flush;
   assign hz.exmem_bubble = exmem_bubble;
   assign hz.mc_timeout   = timeout_flag;
   assign hz.stall_cycles = stall_cnt;
   assign hz.flush_count  = flush_cnt;
   assign hz.dbg_state    = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int MC_TIMEOUT = 8;
   localparam int CNT_W      = 6;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   // Control vector bit order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_MC    = 6'b110101;
   localparam logic [5:0] C_FLUSH = 6'b001010;
   localparam logic [5:0] C_LU    = 6'b110010;
   localparam logic [5:0] C_FETCH = 6'b101000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipeline_hazard_ctrl #(
      .MC_TIMEOUT (MC_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   logic [5:0] exp_q[$];

   // behavioural model: is a multi-cycle op outstanding, and for how many cycles
   bit m_busy;
   int m_waited;
   bit m_timeout;
   int m_stall;
   int m_flush;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mem_rd;
      logic       flush;
      logic       imem;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] dut_ctrl();
      return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall, hz.idex_flush, hz.exmem_bubble};
   endfunction

   function automatic bit model_load_use();
      bit hit1, hit2;
      hit1 = hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd);
      hit2 = hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd);
      return hz.ex_mem_read && (hz.ex_rd != 0) && (hit1 || hit2);
   endfunction

   function automatic logic [5:0] model_ctrl();
      if (m_busy) return C_MC;
      if (hz.ex_mc_start && !hz.mc_done) return C_MC;
      if (hz.flush_needed) return C_FLUSH;
      if (model_load_use()) return C_LU;
      if (!hz.imem_ready) return C_FETCH;
      return C_IDLE;
   endfunction

   task automatic model_reset();
      m_busy    = 0;
      m_waited  = 0;
      m_timeout = 0;
      m_stall   = 0;
      m_flush   = 0;
   endtask

   task automatic model_advance(input logic [5:0] c);
      if (c[5]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (c == C_FLUSH) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (!m_busy) begin
         if (hz.ex_mc_start && !hz.mc_done) begin
            m_busy   = 1;
            m_waited = 0;
         end
      end else begin
         m_waited++;
         if (hz.mc_done) begin
            m_busy = 0;
         end else if (m_waited == MC_TIMEOUT) begin
            m_timeout = 1;
            m_busy    = 0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      hz.id_rs1       = 5'd0;
      hz.id_rs2       = 5'd0;
      hz.id_uses_rs1  = 1'b0;
      hz.id_uses_rs2  = 1'b0;
      hz.ex_rd        = 5'd0;
      hz.ex_mem_read  = 1'b0;
      hz.ex_mc_start  = 1'b0;
      hz.mc_done      = 1'b0;
      hz.flush_needed = 1'b0;
      hz.imem_ready   = 1'b1;
   endtask

   // Inputs are applied just after a rising edge; outputs are compared on the falling edge.
   task automatic step(input bit use_tab, input logic [5:0] tab_exp, input string name);
      logic [5:0] m;
      @(negedge clk);
      m = model_ctrl();
      exp_q.push_back(use_tab ? tab_exp : m);
      check(name, 32'(dut_ctrl()), 32'(exp_q.pop_front()));
      check("state", 32'(hz.dbg_state), m_busy ? 32'd1 : 32'd0);
      check("mc_timeout", 32'(hz.mc_timeout), 32'(m_timeout));
      check("stall_cycles", 32'(hz.stall_cycles), 32'(m_stall));
      check("flush_count", 32'(hz.flush_count), 32'(m_flush));
      model_advance(m);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      #2;
      check("rst_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
      check("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
      check("rst_mc_timeout", 32'(hz.mc_timeout), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      set_idle();
      model_reset();

      //           rs1    rs2    u1    u2    rd     mem   flush imem  expected
      vecs[0] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, C_LU};
      vecs[1] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_IDLE};
      vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, C_IDLE};
      vecs[3] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_FLUSH};
      vecs[4] = '{5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, C_IDLE};
      vecs[5] = '{5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, C_LU};
      vecs[6] = '{5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, C_IDLE};
      vecs[7] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, C_FETCH};
      vecs[8] = '{5'd4, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, C_LU};
      vecs[9] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, C_FLUSH};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         hz.id_rs1       = vecs[i].rs1;
         hz.id_rs2       = vecs[i].rs2;
         hz.id_uses_rs1  = vecs[i].u1;
         hz.id_uses_rs2  = vecs[i].u2;
         hz.ex_rd        = vecs[i].rd;
         hz.ex_mem_read  = vecs[i].mem_rd;
         hz.flush_needed = vecs[i].flush;
         hz.imem_ready   = vecs[i].imem;
         step(1'b1, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // single load-use bubble then idle
      do_reset();
      hz.id_rs2 = 5'd5; hz.id_uses_rs2 = 1'b1; hz.ex_rd = 5'd5; hz.ex_mem_read = 1'b1;
      step(1'b1, C_LU, "lu_stall");
      set_idle();
      step(1'b1, C_IDLE, "lu_release");
      check("lu_stall_cycles", 32'(hz.stall_cycles), 32'd1);

      // load-use coinciding with a redirect
      do_reset();
      hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1; hz.ex_rd = 5'd5; hz.ex_mem_read = 1'b1;
      hz.flush_needed = 1'b1;
      step(1'b1, C_FLUSH, "lu_vs_flush");
      set_idle();
      step(1'b1, C_IDLE, "after_flush");
      check("flush_count_one", 32'(hz.flush_count), 32'd1);

      // multi-cycle op finishing 5 cycles after start
      do_reset();
      hz.ex_mc_start = 1'b1;
      step(1'b1, C_MC, "mc_start");
      hz.ex_mc_start = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, C_MC, "mc_wait");
      hz.flush_needed = 1'b1;
      hz.imem_ready   = 1'b0;
      hz.mc_done      = 1'b1;
      step(1'b1, C_MC, "mc_done_cycle");
      set_idle();
      step(1'b1, C_IDLE, "mc_back_to_run");
      check("mc_stall_cycles", 32'(hz.stall_cycles), 32'd6);

      // start and done in the same cycle: no stall
      do_reset();
      hz.ex_mc_start = 1'b1;
      hz.mc_done     = 1'b1;
      step(1'b1, C_IDLE, "mc_same_cycle");
      set_idle();

      // multi-cycle op that never completes
      do_reset();
      hz.ex_mc_start = 1'b1;
      step(1'b1, C_MC, "to_start");
      hz.ex_mc_start = 1'b0;
      for (int i = 0; i < MC_TIMEOUT; i++) step(1'b1, C_MC, "to_wait");
      step(1'b1, C_IDLE, "to_run");
      check("to_flag", 32'(hz.mc_timeout), 32'd1);
      check("to_stall_cycles", 32'(hz.stall_cycles), 32'(MC_TIMEOUT + 1));
      for (int i = 0; i < 3; i++) step(1'b1, C_IDLE, "to_sticky");
      do_reset();
      check("to_cleared", 32'(hz.mc_timeout), 32'd0);

      // fetch wait for 3 cycles
      hz.imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, C_FETCH, "fetch_wait");
      hz.imem_ready = 1'b1;
      step(1'b1, C_IDLE, "fetch_resume");

      // asynchronous reset in the middle of MC_WAIT
      hz.ex_mc_start = 1'b1;
      step(1'b1, C_MC, "ar_start");
      hz.ex_mc_start = 1'b0;
      step(1'b1, C_MC, "ar_wait");
      #2;
      rst = 1'b1;
      #1;
      check("ar_ctrl", 32'(dut_ctrl()), 32'(C_IDLE));
      check("ar_state", 32'(hz.dbg_state), 32'd0);
      check("ar_stall_cycles", 32'(hz.stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(1'b1, C_IDLE, "ar_run");

      // randomized run, long enough to saturate the counters
      do_reset();
      for (int i = 0; i < 600; i++) begin
         hz.id_rs1       = 5'($urandom_range(0, 7));
         hz.id_rs2       = 5'($urandom_range(0, 7));
         hz.id_uses_rs1  = 1'($urandom_range(0, 1));
         hz.id_uses_rs2  = 1'($urandom_range(0, 1));
         hz.ex_rd        = 5'($urandom_range(0, 7));
         hz.ex_mem_read  = 1'($urandom_range(0, 1));
         hz.ex_mc_start  = ($urandom_range(0, 9) == 0);
         hz.mc_done      = ($urandom_range(0, 5) == 0);
         hz.flush_needed = ($urandom_range(0, 3) == 0);
         hz.imem_ready   = ($urandom_range(0, 3) != 0);
         step(1'b0, C_IDLE, "rand_ctrl");
      end
      set_idle();
      check("sat_stall_cycles", 32'(hz.stall_cycles), 32'(CNT_MAX));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
